// File: rtl/lcu_kogge_stone_pipe.sv
// Pipelined Kogge-Stone lookahead carry unit.
// Each prefix level is followed by one register stage holding {p, g, valid}.
// There is no carry-in, so CO[i] is the group generate of bits [i:0].
// All stages advance together whenever the output is empty or being consumed.
module lcu_kogge_stone_pipe #(
  parameter int WIDTH = 8
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  in_valid,
  output logic                                  in_ready,
  input  logic [WIDTH-1:0]                      P,
  input  logic [WIDTH-1:0]                      G,
  output logic                                  out_valid,
  input  logic                                  out_ready,
  output logic [WIDTH-1:0]                      CO,
  output logic [$clog2($clog2(WIDTH)+1)-1:0]    occupancy
);

  localparam int STAGES = $clog2(WIDTH);
  localparam int OCC_W  = $clog2(STAGES + 1);

  logic                adv;
  logic [STAGES-1:0]   valid_q;
  logic [WIDTH-1:0]    p_q [STAGES];
  logic [WIDTH-1:0]    g_q [STAGES];
  logic [WIDTH-1:0]    p_d [STAGES];
  logic [WIDTH-1:0]    g_d [STAGES];
  logic [OCC_W-1:0]    occ_d;

  // The whole pipe moves as one; a stalled output freezes every stage.
  assign out_valid = valid_q[STAGES-1];
  assign adv       = !out_valid || out_ready;
  assign in_ready  = adv;

  // Prefix level k combines each bit with the bit 2^k positions below it;
  // level 0 works on the raw inputs, level k on the output of stage k-1.
  always_comb begin
    logic [WIDTH-1:0] cur_p;
    logic [WIDTH-1:0] cur_g;
    // NOTE: every combinational output gets a default before any conditional
    // update, so no path leaves it unassigned and no latch is inferred.
    cur_p = P;
    cur_g = G;
    for (int k = 0; k < STAGES; k++) begin
      p_d[k] = cur_p;
      g_d[k] = cur_g;
      for (int i = (1 << k); i < WIDTH; i++) begin
        g_d[k][i] = cur_g[i] | (cur_p[i] & cur_g[i-(1<<k)]);
        p_d[k][i] = cur_p[i] & cur_p[i-(1<<k)];
      end
      cur_p = p_q[k];
      cur_g = g_q[k];
    end
  end

  // Valid bits shift on every advance; a missing operand becomes a bubble.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples the pre-edge value of the stage before it.
    if (!rst_n) begin
      valid_q <= '0;
    end else if (adv) begin
      valid_q[0] <= in_valid;
      for (int k = 1; k < STAGES; k++) begin
        valid_q[k] <= valid_q[k-1];
      end
    end
  end

  // Prefix data registers follow the valid bits on every advance.
  always_ff @(posedge clk) begin
    // NOTE: data registers carry no reset; the valid bits alone decide whether
    // their contents mean anything, and CO is masked while out_valid is low.
    if (adv) begin
      for (int k = 0; k < STAGES; k++) begin
        p_q[k] <= p_d[k];
        g_q[k] <= g_d[k];
      end
    end
  end

  // Occupancy is the population count of the stage valid bits.
  always_comb begin
    occ_d = '0;
    for (int k = 0; k < STAGES; k++) begin
      occ_d = occ_d + OCC_W'(valid_q[k]);
    end
  end

  assign occupancy = occ_d;
  assign CO        = out_valid ? g_q[STAGES-1] : '0;

endmodule

// File: tb/tb_lcu_kogge_stone_pipe.sv
// Bench for lcu_kogge_stone_pipe: directed vectors on an 8-bit instance,
// then random streams with random stalls on 2, 5, 8 and 64-bit instances.
module tb_lcu_kogge_stone_pipe;

  typedef struct {
    logic [7:0] p;
    logic [7:0] g;
    logic [7:0] co;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, out_valid, out_ready;
  logic [7:0] p, g, co, cur_exp;
  logic [1:0] occ;
  logic       rand_go = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  lcu_kogge_stone_pipe #(.WIDTH(8)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .P         (p),
    .G         (g),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .CO        (co),
    .occupancy (occ)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Ripple reference: CO[i] = G[i] | (P[i] & CO[i-1]), no carry-in.
  function automatic logic [63:0] ripple64(input logic [63:0] rp, input logic [63:0] rg,
                                           input int w);
    logic [63:0] r;
    logic        c;
    r = '0;
    c = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (i < w) begin
        c    = rg[i] | (rp[i] & c);
        r[i] = c;
      end
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard for the 8-bit instance: handshakes are judged mid-cycle,
  // where inputs and outputs are stable ahead of the edge that acts on them.
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) exp_q.push_back(cur_exp);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) check("unexpected_output", {56'd0, co}, 64'hx);
        else check("sb_co", {56'd0, co}, {56'd0, exp_q.pop_front()});
      end
      if (!out_valid) check("co_zero_when_idle", {56'd0, co}, 64'd0);
    end
  end

  // Random streams, one per width, each with its own scoreboard.
  for (genvar j = 0; j < 4; j++) begin : g_rand
    localparam int RW = (j == 0) ? 2 : (j == 1) ? 5 : (j == 2) ? 8 : 64;
    localparam int RS = $clog2(RW);
    localparam int RO = $clog2(RS + 1);
    localparam int N  = (RW == 8) ? 10000 : 3000;

    logic          iv, ir, ov, ordy, done;
    logic [RW-1:0] rp, rg, rco;
    logic [RO-1:0] rocc;
    logic [RW-1:0] q[$];

    lcu_kogge_stone_pipe #(.WIDTH(RW)) u_rand (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (iv),
      .in_ready  (ir),
      .P         (rp),
      .G         (rg),
      .out_valid (ov),
      .out_ready (ordy),
      .CO        (rco),
      .occupancy (rocc)
    );

    task automatic sample(output logic accepted);
      accepted = iv && ir;
      check($sformatf("w%0d_in_ready", RW), {63'd0, ir}, {63'd0, !ov || ordy});
      if (accepted) q.push_back(RW'(ripple64(64'(rp), 64'(rg), RW)));
      if (ov && ordy) begin
        if (q.size() == 0) check($sformatf("w%0d_unexpected", RW), 64'(rco), 64'hx);
        else check($sformatf("w%0d_co", RW), 64'(rco), 64'(q.pop_front()));
      end
      if (!ov) check($sformatf("w%0d_co_idle", RW), 64'(rco), 64'd0);
    endtask

    initial begin
      int   sent;
      int   cyc;
      logic acc;
      done = 1'b0;
      iv   = 1'b0;
      ordy = 1'b1;
      rp   = '0;
      rg   = '0;
      wait (rand_go);
      @(posedge clk);
      #1;
      sent = 0;
      cyc  = 0;
      while (sent < N && cyc < 40000) begin
        iv   = ($urandom_range(0, 3) != 0);
        rp   = RW'({$urandom(), $urandom()});
        rg   = RW'({$urandom(), $urandom()});
        ordy = ($urandom_range(0, 3) != 0);
        @(negedge clk);
        sample(acc);
        if (acc) sent++;
        @(posedge clk);
        #1;
        cyc++;
      end
      check($sformatf("w%0d_sent_all", RW), 64'(sent), 64'(N));
      iv   = 1'b0;
      ordy = 1'b1;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        sample(acc);
        @(posedge clk);
        #1;
      end
      check($sformatf("w%0d_drained", RW), 64'(q.size()), 64'd0);
      done = 1'b1;
    end
  end

  vec_t vecs[8];

  initial begin
    logic [7:0] held;
    logic       all_done;

    vecs[0] = '{8'hFF, 8'h01, 8'hFF};
    vecs[1] = '{8'h00, 8'hA5, 8'hA5};
    vecs[2] = '{8'h0F, 8'h10, 8'h10};
    vecs[3] = '{8'hF0, 8'h10, 8'hF0};
    vecs[4] = '{8'hFE, 8'h01, 8'hFF};
    vecs[5] = '{8'h7F, 8'h80, 8'h80};
    vecs[6] = '{8'hAA, 8'h55, 8'hFF};
    vecs[7] = '{8'h0F, 8'h01, 8'h0F};

    // Reset state.
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    p = '0; g = '0; cur_exp = '0;
    tick(); tick();
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_occupancy", {62'd0, occ}, 64'd0);
    check("rst_co", {56'd0, co}, 64'd0);
    out_ready = 1'b0;
    #1;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    out_ready = 1'b1;
    rst_n = 1'b1;
    tick();

    // Single operand: result three edges after it is presented, then gone.
    p = vecs[0].p; g = vecs[0].g; cur_exp = vecs[0].co; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    check("single_occ1", {62'd0, occ}, 64'd1);
    check("single_ov_e1", {63'd0, out_valid}, 64'd0);
    tick();
    check("single_ov_e2", {63'd0, out_valid}, 64'd0);
    tick();
    check("single_ov_e3", {63'd0, out_valid}, 64'd1);
    check("single_co", {56'd0, co}, {56'd0, vecs[0].co});
    tick();
    check("single_ov_e4", {63'd0, out_valid}, 64'd0);

    // Back-to-back stream: one result per cycle, full pipe stays full.
    for (int t = 1; t <= 9; t++) begin
      if (t <= 7) begin
        p = vecs[t].p; g = vecs[t].g; cur_exp = vecs[t].co; in_valid = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      tick();
      if (t >= 3) begin
        check($sformatf("stream_ov_%0d", t), {63'd0, out_valid}, 64'd1);
        check($sformatf("stream_co_%0d", t), {56'd0, co}, {56'd0, vecs[t-2].co});
      end
      if (t >= 3 && t <= 7) check($sformatf("stream_occ_%0d", t), {62'd0, occ}, 64'd3);
    end
    tick();
    check("stream_end_ov", {63'd0, out_valid}, 64'd0);
    check("stream_queue_empty", 64'(exp_q.size()), 64'd0);

    // Backpressure: fill, stall five cycles while wiggling inputs, then drain.
    for (int t = 1; t <= 3; t++) begin
      p = vecs[t].p; g = vecs[t].g; cur_exp = vecs[t].co; in_valid = 1'b1;
      tick();
    end
    out_ready = 1'b0;
    held = co;
    check("bp_first_co", {56'd0, held}, {56'd0, vecs[1].co});
    for (int t = 0; t < 5; t++) begin
      p = 8'($urandom()); g = 8'($urandom()); cur_exp = 8'hEE; in_valid = 1'b1;
      #1;
      check("bp_in_ready", {63'd0, in_ready}, 64'd0);
      tick();
      check("bp_occ", {62'd0, occ}, 64'd3);
      check("bp_ov", {63'd0, out_valid}, 64'd1);
      check("bp_co_hold", {56'd0, co}, {56'd0, held});
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_drain2", {56'd0, co}, {56'd0, vecs[2].co});
    tick();
    check("bp_drain3", {56'd0, co}, {56'd0, vecs[3].co});
    tick();
    check("bp_drain_end", {63'd0, out_valid}, 64'd0);
    check("bp_queue_empty", 64'(exp_q.size()), 64'd0);

    // Reset with two operands in flight: both are discarded.
    for (int t = 4; t <= 5; t++) begin
      p = vecs[t].p; g = vecs[t].g; cur_exp = vecs[t].co; in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    exp_q.delete();
    tick();
    check("midrst_ov", {63'd0, out_valid}, 64'd0);
    check("midrst_occ", {62'd0, occ}, 64'd0);
    check("midrst_co", {56'd0, co}, 64'd0);
    rst_n = 1'b1;
    for (int t = 0; t < 5; t++) tick();
    check("postrst_occ", {62'd0, occ}, 64'd0);

    // First operand after reset still takes three edges.
    p = vecs[6].p; g = vecs[6].g; cur_exp = vecs[6].co; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    check("postrst_ov_e2", {63'd0, out_valid}, 64'd0);
    tick();
    check("postrst_ov_e3", {63'd0, out_valid}, 64'd1);
    check("postrst_co", {56'd0, co}, {56'd0, vecs[6].co});
    tick();

    // Random streams on all widths.
    rand_go = 1'b1;
    all_done = 1'b0;
    for (int c = 0; c < 60000 && !all_done; c++) begin
      @(posedge clk);
      all_done = g_rand[0].done && g_rand[1].done && g_rand[2].done && g_rand[3].done;
    end
    check("random_finished", {63'd0, all_done}, 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lcu_kogge_stone_pipe.md
LCU_KOGGE_STONE_PIPE -- requirements
Module: lcu_kogge_stone_pipe

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: carry-chain width in bits; legal range 2..64.
REQ-002 The block SHALL have derived localparam STAGES = ceil(log2(WIDTH)): number of prefix levels, and therefore number of pipeline registers.
REQ-003 Port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-005 Port in_valid, input, 1 bit: the P/G operand pair is presented.
REQ-006 Port in_ready, output, 1 bit: the block accepts the operand this cycle.
REQ-007 Port P, input, WIDTH bits: per-bit propagate.
REQ-008 Port G, input, WIDTH bits: per-bit generate.
REQ-009 Port out_valid, output, 1 bit: CO holds a valid result.
REQ-010 Port out_ready, input, 1 bit: the downstream consumer accepts CO.
REQ-011 Port CO, output, WIDTH bits: carry-out vector.
REQ-012 Port occupancy, output, clog2(STAGES+1) bits: number of valid pipeline stages.

Function
REQ-013 The block SHALL compute CO[i] = G[i] | (P[i] & CO[i-1]), with CO[-1] = 0 (no carry-in), bit-exact with the LCU_<WIDTH> operator semantics.
REQ-014 The block SHALL use a Kogge-Stone prefix structure.
  - Level k (k = 0..STAGES-1) uses span d = 2^k.
  - For i >= d: g'[i] = g[i] | (p[i] & g[i-d]); p'[i] = p[i] & p[i-d].
  - For i < d: bits pass unchanged.
REQ-015 Each prefix level SHALL be followed by one register stage holding {p, g, valid}; CO SHALL be the g vector of the final stage.
REQ-016 Latency SHALL be exactly STAGES cycles from the accepting edge to out_valid=1 when out_ready is held at 1 (WIDTH=8: 3 cycles).
REQ-017 The pipeline SHALL use a global advance: adv = !out_valid | out_ready.
  - in_ready = adv.
  - All stages shift only when adv = 1.
REQ-018 An operand SHALL be accepted on an edge where in_valid & in_ready.
REQ-019 When adv = 1 and in_valid = 0, a bubble (valid = 0) SHALL enter stage 0.
REQ-020 When out_valid=1 and out_ready=0, CO and out_valid SHALL hold stable and no stage SHALL change.
REQ-021 Input P/G SHALL be sampled only on acceptance; P/G changes while in_ready=0 SHALL have no effect.
REQ-022 With in_valid=1 and out_ready=1 held continuously, throughput SHALL be one result per cycle.
REQ-023 Results SHALL emerge in acceptance order, with no loss or duplication.
REQ-024 occupancy SHALL equal the count of stage valid bits; maximum value STAGES.
REQ-025 When full with out_ready=1 and in_valid=1, a result SHALL be emitted and an operand accepted on the same edge; occupancy stays STAGES.
REQ-026 in_ready SHALL depend combinationally only on out_valid and out_ready, never on in_valid.
REQ-027 Data registers of invalid stages MAY hold arbitrary values, but CO SHALL be 0 whenever out_valid = 0.

Reset
REQ-028 While rst_n = 0 at a clock edge, all stage valid bits SHALL clear, giving out_valid = 0, occupancy = 0 and CO = 0.
REQ-029 During reset, in_ready SHALL read 1.
REQ-030 A reset asserted mid-operation SHALL discard every in-flight operand; no result from before reset SHALL appear afterwards.
REQ-031 The first operand accepted after rst_n rises SHALL appear STAGES cycles later.

Verification (WIDTH=8, STAGES=3)
REQ-032 Single operand: P=8'hFF, G=8'h01 accepted at cycle 0, out_ready=1 -> out_valid=1 at cycle 3 with CO=8'hFF; out_valid=0 at cycle 4.
REQ-033 Back-to-back operands with out_ready=1:
  - (P=8'h00, G=8'hA5) -> CO=8'hA5.
  - (P=8'h0F, G=8'h10) -> CO=8'h10.
  - (P=8'hF0, G=8'h10) -> CO=8'hF0.
  - Results appear on consecutive cycles 3, 4, 5.
REQ-034 Backpressure: fill 3 operands, then out_ready=0 for 5 cycles -> in_ready=0, occupancy=3, and CO/out_valid hold stable; on release, all 3 results drain in order with no duplicates.
REQ-035 Reset mid-flight: 2 operands in flight, rst_n=0 for one edge -> out_valid=0, occupancy=0, CO=0; no stale result is ever emitted.
REQ-036 Random: 10k random P/G values with random in_valid and out_ready -> every CO matches the ripple reference model of REQ-013, in order; also run at WIDTH=2, 5 and 64.
